// File: rtl/ram_prog_arbiter.sv
// ram_prog_arbiter: shares the CPU RAM port with an external byte loader and sequences programming sessions
module ram_prog_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_req,
    input  logic              cpu_boundary,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_valid,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_last,
    output logic              ext_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_halt,
    output logic              cpu_restart,
    output logic              prog_done,
    output logic              busy,
    output logic              load_trunc
);
    typedef enum logic [2:0] {RUN, DRAIN, LOAD, CLEAR, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prog_req_q, prog_req_d;
    logic              load_trunc_q, load_trunc_d;
    logic              at_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            prog_req_q   <= 1'b0;
            load_trunc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prog_req_q   <= prog_req_d;
            load_trunc_q <= load_trunc_d;
        end
    end
    assign at_last = cnt_q == LAST;
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prog_req_d   = prog_req;
        load_trunc_d = load_trunc_q;
        ram_addr     = cnt_q;
        ram_wdata    = '0;
        ram_we       = 1'b0;
        case (state_q)
            RUN: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
                state_d   = (prog_req && !prog_req_q) ? DRAIN : RUN;
            end
            DRAIN: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
                if (cpu_boundary) begin
                    state_d      = LOAD;
                    cnt_d        = '0;
                    load_trunc_d = 1'b0;
                end
            end
            LOAD: begin
                // loader writes are suppressed while reset is asserted so an aborted session leaves RAM untouched
                ram_wdata = ext_data;
                ram_we    = ext_valid && !rst;
                if (ext_valid) begin
                    if (at_last) begin
                        state_d      = DONE;
                        load_trunc_d = !ext_last;
                    end else begin
                        state_d = ext_last ? CLEAR : LOAD;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                ram_we  = !rst;
                state_d = at_last ? DONE : CLEAR;
                cnt_d   = at_last ? cnt_q : cnt_q + 1'b1;
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end
    assign cpu_rdata   = ram_rdata;
    assign ext_ready   = state_q == LOAD;
    assign cpu_halt    = state_q == LOAD || state_q == CLEAR || state_q == DONE;
    assign busy        = state_q != RUN;
    assign cpu_restart = state_q == DONE;
    assign prog_done   = state_q == DONE;
    assign load_trunc  = load_trunc_q;
endmodule

// File: tb/tb_ram_prog_arbiter.sv
// tb_ram_prog_arbiter: randomized session-level checks of the RAM programming arbiter against a RAM image model
module tb_ram_prog_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int D  = 16;
    logic          clk = 1'b0;
    logic          rst, prog_req, cpu_boundary, cpu_we, ext_valid, ext_last;
    logic [AW-1:0] cpu_addr, ram_addr;
    logic [DW-1:0] cpu_wdata, ext_data, ram_wdata, ram_rdata, cpu_rdata;
    logic          ext_ready, ram_we, cpu_halt, cpu_restart, prog_done, busy, load_trunc;
    logic [4:0]    flags;
    logic [DW-1:0] mem [D];
    logic [DW-1:0] exp_mem [D];
    logic [DW-1:0] img [D];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];
    assign flags = {busy, cpu_halt, ext_ready, prog_done, cpu_restart};

    ram_prog_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .prog_req(prog_req), .cpu_boundary(cpu_boundary),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .ext_valid(ext_valid), .ext_data(ext_data), .ext_last(ext_last), .ext_ready(ext_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .cpu_halt(cpu_halt), .cpu_restart(cpu_restart), .prog_done(prog_done), .busy(busy),
        .load_trunc(load_trunc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; prog_req = 1; ext_valid = 1; ext_data = 8'hAA; ext_last = 1;
        cpu_boundary = 1; cpu_we = 1; cpu_addr = 4'h9; cpu_wdata = 8'h5C;
        tick; tick; #2;
        n_checks++;
        if (flags !== 5'b0 || load_trunc !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b/%b exp 00000/0", flags, load_trunc);
        end
        n_checks++;
        if (ram_we !== 1'b1 || ram_addr !== 4'h9 || ram_wdata !== 8'h5C) begin
            n_fail++; $display("FAIL reset_mux: got we=%b a=%h d=%h exp we=1 a=9 d=5c", ram_we, ram_addr, ram_wdata);
        end
        cpu_we = 0; #1;
        n_checks++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_follow: got %b exp 0", ram_we); end
        rst = 0; prog_req = 0; ext_valid = 0; ext_last = 0; cpu_boundary = 0;
        tick; #2;
        n_checks++;
        if (flags !== 5'b0) begin n_fail++; $display("FAIL reset_release: got %b exp 00000", flags); end
        tick;
    endtask

    // raise prog_req from low, optionally wait in DRAIN with a CPU write to address 5, then grant the boundary
    task automatic start_session(input int drain);
        prog_req = 0; cpu_we = 0; cpu_boundary = 0; ext_valid = 0; ext_last = 0;
        tick;
        prog_req = 1; #2;
        n_checks++;
        if (flags !== 5'b0) begin n_fail++; $display("FAIL start_run: got %b exp 00000", flags); end
        tick;
        for (int i = 0; i < drain; i++) begin
            cpu_we = 1; cpu_addr = 4'd5; cpu_wdata = 8'h77; #2;
            n_checks++;
            if (flags !== 5'b10000 || ram_we !== 1'b1 || ram_addr !== 4'd5 || ram_wdata !== 8'h77) begin
                n_fail++; $display("FAIL drain_hold: got f=%b we=%b a=%h d=%h exp f=10000 we=1 a=5 d=77", flags, ram_we, ram_addr, ram_wdata);
            end
            tick;
        end
        if (drain > 0) begin
            n_checks++;
            if (mem[5] !== 8'h77) begin n_fail++; $display("FAIL drain_write: got %h exp 77", mem[5]); end
        end
        cpu_we = 0; cpu_boundary = 1; #2;
        n_checks++;
        if (flags !== 5'b10000) begin n_fail++; $display("FAIL drain_exit: got %b exp 10000", flags); end
        tick;
        cpu_boundary = 0;
    endtask

    // stream img[0..nb-1]; gap<0 means random idle cycles before each byte
    task automatic do_load(input int nb, input bit lastf, input int gap, input bit abort);
        bit lt = (nb == D) && !lastf;
        bit aborted = 0;
        for (int k = 0; k < nb; k++) begin
            int g = (gap < 0) ? int'($urandom_range(0, 2)) : ((k == 0) ? 0 : gap);
            for (int j = 0; j < g; j++) begin
                ext_valid = 0; ext_data = 8'($urandom); ext_last = 1'($urandom);
                cpu_we = 1; cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom); #2;
                n_checks++;
                if (flags !== 5'b11100 || ram_we !== 1'b0) begin
                    n_fail++; $display("FAIL load_idle: got f=%b we=%b exp f=11100 we=0", flags, ram_we);
                end
                tick;
            end
            ext_valid = 1; ext_data = img[k]; ext_last = lastf && (k == nb - 1);
            cpu_we = 1; cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom); #2;
            n_checks++;
            if (flags !== 5'b11100 || ram_we !== 1'b1 || ram_addr !== AW'(k) || ram_wdata !== img[k]) begin
                n_fail++; $display("FAIL load_byte: got f=%b we=%b a=%h d=%h exp f=11100 we=1 a=%h d=%h",
                                   flags, ram_we, ram_addr, ram_wdata, AW'(k), img[k]);
            end
            tick;
        end
        ext_valid = 0; ext_last = 0;
        for (int k = nb; k < D && !aborted; k++) begin
            cpu_we = 1; cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom);
            if (abort && k == nb) begin
                rst = 1; prog_req = 0; #2;
                n_checks++;
                if (ram_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %b exp 0", ram_we); end
                tick;
                rst = 0; cpu_we = 0; #2;
                n_checks++;
                if (flags !== 5'b0 || load_trunc !== 1'b0) begin
                    n_fail++; $display("FAIL abort_run: got %b/%b exp 00000/0", flags, load_trunc);
                end
                tick; #2;
                n_checks++;
                if (flags !== 5'b0) begin n_fail++; $display("FAIL abort_stay: got %b exp 00000", flags); end
                aborted = 1;
            end else begin
                #2;
                n_checks++;
                if (flags !== 5'b11000 || ram_we !== 1'b1 || ram_addr !== AW'(k) || ram_wdata !== 8'h00) begin
                    n_fail++; $display("FAIL clear: got f=%b we=%b a=%h d=%h exp f=11000 we=1 a=%h d=00",
                                       flags, ram_we, ram_addr, ram_wdata, AW'(k));
                end
                tick;
            end
        end
        if (!aborted) begin
            ext_valid = 1; ext_data = 8'hEE; cpu_we = 1; #2;
            n_checks++;
            if (flags !== 5'b11011 || ram_we !== 1'b0 || load_trunc !== lt) begin
                n_fail++; $display("FAIL done: got f=%b we=%b tr=%b exp f=11011 we=0 tr=%b", flags, ram_we, load_trunc, lt);
            end
            tick;
            cpu_we = 0; #2;
            n_checks++;
            if (flags !== 5'b0 || ram_we !== 1'b0 || load_trunc !== lt) begin
                n_fail++; $display("FAIL after_done: got f=%b we=%b tr=%b exp f=00000 we=0 tr=%b", flags, ram_we, load_trunc, lt);
            end
            ext_valid = 0;
        end
        for (int i = 0; i < D; i++) exp_mem[i] = (i < nb) ? img[i] : (aborted ? exp_mem[i] : 8'h00);
        for (int i = 0; i < D; i++) begin
            n_checks++;
            if (mem[i] !== exp_mem[i]) begin
                n_fail++; $display("FAIL ram_image[%0d]: got %h exp %h", i, mem[i], exp_mem[i]);
            end
        end
        cpu_we = 0; cpu_addr = 4'($urandom); #1;
        n_checks++;
        if (cpu_rdata !== exp_mem[cpu_addr]) begin
            n_fail++; $display("FAIL cpu_rdata: got %h exp %h", cpu_rdata, exp_mem[cpu_addr]);
        end
        tick;
    endtask

    task automatic test_short_load;
        img[0] = 8'h1A; img[1] = 8'h2B; img[2] = 8'h3C;
        start_session(0);
        do_load(3, 1, 0, 0);
    endtask

    task automatic test_drain_hold;
        int nb = $urandom_range(3, 5);
        for (int i = 0; i < D; i++) img[i] = 8'($urandom);
        start_session(4);
        do_load(nb, 1, -1, 0);
    endtask

    task automatic test_gapped;
        for (int i = 0; i < 4; i++) img[i] = 8'(i + 1);
        start_session(0);
        do_load(4, 1, 2, 0);
    endtask

    task automatic test_full;
        for (int i = 0; i < D; i++) img[i] = 8'(8'hF0 + i);
        start_session(0);
        do_load(D, 0, 0, 0);
        tick; #2;
        n_checks++;
        if (load_trunc !== 1'b1) begin n_fail++; $display("FAIL trunc_sticky: got %b exp 1", load_trunc); end
        start_session(0);
        do_load(D, 1, 0, 0);
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < D; i++) img[i] = 8'($urandom);
        start_session(0);
        do_load(7, 1, 0, 1);
    endtask

    task automatic test_retrigger;
        int nb = $urandom_range(1, D);
        for (int i = 0; i < D; i++) img[i] = 8'($urandom);
        start_session(0);
        do_load(nb, 1, -1, 0);
        for (int i = 0; i < 5; i++) begin
            #2;
            n_checks++;
            if (flags !== 5'b0) begin n_fail++; $display("FAIL retrigger_held: got %b exp 00000", flags); end
            tick;
        end
        nb = $urandom_range(1, D);
        start_session(0);
        do_load(nb, 1, -1, 0);
    endtask

    task automatic test_random;
        for (int s = 0; s < 8; s++) begin
            int nb = $urandom_range(1, D);
            bit lastf = (nb < D) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < D; i++) img[i] = 8'($urandom);
            start_session($urandom_range(0, 3));
            do_load(nb, lastf, -1, 0);
        end
    endtask

    initial begin
        test_reset;
        test_short_load;
        test_drain_hold;
        test_gapped;
        test_full;
        test_mid_reset;
        test_retrigger;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_prog_arbiter.md
Name: ram_prog_arbiter

Overview:
- Owns the single port of the 16x8 program/data RAM in the 8-bit CPU.
- Shares that port between the CPU datapath (normal run) and an external byte loader (programming mode).
- Sequences each programming session:
  - waits for an instruction boundary, then halts the CPU;
  - streams bytes into RAM from address 0 and zero-fills the unused tail;
  - pulses a restart so the program counter returns to 0.

Parameters:
ADDR_W, 4, RAM address width.
DATA_W, 8, RAM/bus data width.
DEPTH, 16, number of RAM words (must equal 2**ADDR_W).

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
prog_req  input  1  programming request; a new session starts only on a 0->1 transition seen in RUN
cpu_boundary  input  1  high when control block is at fetch step T0 (safe to take RAM)
cpu_addr  input  ADDR_W  CPU RAM address (from MAR)
cpu_wdata  input  DATA_W  CPU write data (from bus)
cpu_we  input  1  CPU RAM write strobe
cpu_rdata  output  DATA_W  RAM read data to CPU; equals ram_rdata combinationally in all states
ext_valid  input  1  loader byte valid
ext_data  input  DATA_W  loader byte
ext_last  input  1  marks final byte of program, qualified by ext_valid
ext_ready  output  1  arbiter accepts a loader byte this cycle
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_we  output  1  RAM write enable
ram_rdata  input  DATA_W  RAM read data
cpu_halt  output  1  freezes PC and control block step counter
cpu_restart  output  1  one-cycle pulse; clears PC to 0
prog_done  output  1  one-cycle pulse at end of session
busy  output  1  high in any state other than RUN
load_trunc  output  1  sticky; RAM filled before ext_last was seen

Behaviour:
- States: RUN, DRAIN, LOAD, CLEAR, DONE. A 4-bit word counter cnt is used in LOAD and CLEAR.
- Reset (sync, rst=1 at posedge):
  - state=RUN, cnt=0, prog_req_q=0, load_trunc=0;
  - all pulse and handshake outputs are 0; cpu_halt=0.
  - Reset mid-session returns to RUN the next cycle. Partially written RAM is not restored.
- RAM mux:
  - In RUN and DRAIN: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we.
  - In LOAD, CLEAR and DONE: the CPU is disconnected; cpu_we is ignored.
- RUN:
  - Request detect: prog_req_q is prog_req registered every cycle; start when prog_req=1 and prog_req_q=0.
  - Start -> DRAIN.
  - A prog_req held high across a session does not start a new one.
- DRAIN:
  - cpu_halt=0 and the CPU still owns RAM.
  - When cpu_boundary=1 -> LOAD, with cnt=0 and load_trunc cleared.
  - The block waits in DRAIN indefinitely while cpu_boundary=0.
- LOAD:
  - cpu_halt=1, ext_ready=1.
  - On ext_valid=1 (same cycle): ram_we=1, ram_addr=cnt, ram_wdata=ext_data.
  - With ext_valid=0: ram_we=0 and the block stays in LOAD.
  - After an accepted byte:
    - cnt=DEPTH-1 and ext_last=1 -> DONE.
    - cnt=DEPTH-1 and ext_last=0 -> DONE and load_trunc=1. Further loader bytes are not accepted (ext_ready=0).
    - ext_last=1 and cnt<DEPTH-1 -> CLEAR with cnt+1.
    - Otherwise cnt+1 and stay in LOAD.
- CLEAR:
  - cpu_halt=1, ext_ready=0.
  - Each cycle: ram_we=1, ram_addr=cnt, ram_wdata=0, cnt+1.
  - The write at cnt=DEPTH-1 -> DONE.
  - Takes DEPTH-1-k cycles after the last byte written at address k.
- DONE:
  - Lasts exactly one cycle: cpu_halt=1, cpu_restart=1, prog_done=1, ram_we=0.
  - Next state RUN, with cpu_halt=0 on the following cycle.
- busy=1 in DRAIN, LOAD, CLEAR and DONE.
- load_trunc holds its value until the next session enters LOAD, or until reset.
- cnt wrap: cnt never increments past DEPTH-1. The transition out of LOAD/CLEAR takes priority over the increment.
- Outputs ext_ready, cpu_halt and busy are decoded from state. All are glitch-free registered-state decodes.

Test Plan:
- Reset: rst=1 for 2 cycles with prog_req=1 and ext_valid=1 -> state RUN, cpu_halt=0, ext_ready=0, ram_we follows cpu_we, load_trunc=0, prog_done=0.
- Short load:
  - Stimulus: prog_req 0->1 with cpu_boundary=1, then bytes 0x1A, 0x2B, 0x3C back-to-back, ext_last on 0x3C.
  - RAM[0..2] = 1A, 2B, 3C.
  - 13 CLEAR cycles write 0 to addresses 3..15.
  - DONE: prog_done and cpu_restart high for one cycle, then RUN.
  - load_trunc=0.
- Drain hold:
  - Stimulus: prog_req rises while cpu_boundary=0 for 4 cycles, with cpu_we=1, cpu_addr=5, cpu_wdata=0x77.
  - RAM[5]=0x77 is written, busy=1, ext_ready=0, cpu_halt=0.
  - cpu_boundary=1 -> LOAD next cycle.
- Gapped stream:
  - Stimulus: bytes 0x01..0x04 with ext_valid low for 2 cycles between each; ext_last on 0x04; cpu_we=1 throughout.
  - ram_we is asserted only in ext_valid cycles; RAM[0..3] = 01..04.
  - CPU writes are never forwarded during LOAD/CLEAR.
- Full/truncated:
  - Stimulus: 16 bytes 0xF0..0xFF with no ext_last, then a 17th byte presented.
  - After the 16th byte: DONE, load_trunc=1, no CLEAR cycles, 17th byte not accepted.
  - Repeat with ext_last on the 16th byte -> load_trunc=0.
- Re-trigger and mid-session reset:
  - Stimulus: hold prog_req=1 through a whole session -> no second session; a new 0->1 starts one.
  - Stimulus: assert rst during CLEAR at cnt=7 -> RUN next cycle, cpu_halt=0, no prog_done, RAM[7..15] left unchanged.
